// File: rtl/disp_scan_hold.sv
// Debug display back end: captures CPU-domain bus snapshots, holds each
// for a minimum time and scan-multiplexes it onto a 4-digit 7-seg display.
module disp_scan_hold #(
    parameter int C_SCAN     = 10,
    parameter int HOLD_TICKS = 250,
    parameter int BLANK_CYC  = 8
) (
    input  logic        clk_1m,
    input  logic        rst_n,
    input  logic        cap_tgl_i,
    input  logic [15:0] number_i,
    input  logic [3:0]  dot_i,
    input  logic        freeze_i,
    output logic [3:0]  disp_sel,
    output logic [7:0]  disp_seg,
    output logic        busy_o,
    output logic [7:0]  drop_cnt_o
);

    localparam logic [9:0]        HOLD_V  = 10'(HOLD_TICKS);
    localparam logic [C_SCAN-1:0] BLANK_V = C_SCAN'(BLANK_CYC);

    logic              s1, s2, s3;
    logic [15:0]       shadow, pend;
    logic [3:0]        shadow_dot, pend_dot;
    logic              pend_v;
    logic [9:0]        hold;
    logic [7:0]        drop;
    logic [C_SCAN-1:0] presc, presc_nxt;
    logic [1:0]        k, k_nxt;
    logic              tick, evt, idle, commit_now, commit_pend;
    logic [3:0]        nib;
    logic [6:0]        hex;

    assign evt         = s2 ^ s3;
    assign idle        = (hold == 10'd0);
    assign commit_now  = evt && idle && !freeze_i;
    assign commit_pend = !evt && idle && !freeze_i && pend_v;
    assign tick        = &presc;
    assign presc_nxt   = presc + 1'b1;
    assign k_nxt       = tick ? k + 2'd1 : k;
    assign busy_o      = !idle;
    assign drop_cnt_o  = drop;

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= cap_tgl_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            shadow_dot <= '0;
            pend       <= '0;
            pend_dot   <= '0;
            pend_v     <= 1'b0;
            hold       <= '0;
            drop       <= '0;
        end else begin
            if (commit_now) begin
                shadow     <= number_i;
                shadow_dot <= dot_i;
                pend_v     <= 1'b0;
            end else if (evt) begin
                pend     <= number_i;
                pend_dot <= dot_i;
                pend_v   <= 1'b1;
            end else if (commit_pend) begin
                shadow     <= pend;
                shadow_dot <= pend_dot;
                pend_v     <= 1'b0;
            end
            // An event always displaces a waiting snapshot, whichever path it takes
            if (evt && pend_v && drop != 8'hFF)
                drop <= drop + 8'd1;
            if (commit_now || commit_pend)
                hold <= HOLD_V;
            else if (tick && !idle)
                hold <= hold - 10'd1;
        end
    end

    assign nib = shadow[{k_nxt, 2'b00} +: 4];

    always_comb begin
        hex = 7'h7F;
        case (nib)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            4'hF: hex = 7'h0E;
            default: hex = 7'h7F;
        endcase
    end

    // Outputs follow next-state scan values so blanking aligns with prescaler 0
    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            k        <= '0;
            disp_sel <= 4'b1111;
            disp_seg <= 8'hFF;
        end else begin
            presc <= presc_nxt;
            k     <= k_nxt;
            if (presc_nxt < BLANK_V) begin
                disp_sel <= 4'b1111;
                disp_seg <= 8'hFF;
            end else begin
                disp_sel <= ~(4'b0001 << k_nxt);
                disp_seg <= {~shadow_dot[k_nxt], hex};
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_hold.sv
// Directed bench for disp_scan_hold (C_SCAN=4, HOLD_TICKS=3, BLANK_CYC=2).
module tb_disp_scan_hold;

    logic        clk_1m = 1'b0;
    logic        rst_n = 1'b0;
    logic        cap_tgl_i = 1'b0;
    logic [15:0] number_i = '0;
    logic [3:0]  dot_i = '0;
    logic        freeze_i = 1'b0;
    logic [3:0]  disp_sel;
    logic [7:0]  disp_seg;
    logic        busy_o;
    logic [7:0]  drop_cnt_o;

    int nvec = 0;
    int nerr = 0;
    int cyc;

    disp_scan_hold #(.C_SCAN(4), .HOLD_TICKS(3), .BLANK_CYC(2)) dut (
        .clk_1m(clk_1m), .rst_n(rst_n), .cap_tgl_i(cap_tgl_i),
        .number_i(number_i), .dot_i(dot_i), .freeze_i(freeze_i),
        .disp_sel(disp_sel), .disp_seg(disp_seg),
        .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_1m = ~clk_1m;

    // Posedges since reset release; prescaler wraps (tick edge) when cyc%16==0
    always @(posedge clk_1m or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk_1m);
        #1;
    endtask

    task automatic toggle(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk_1m);
        number_i = v;
        dot_i = d;
        cap_tgl_i = ~cap_tgl_i;
    endtask

    task automatic wait_sel(input logic [3:0] s, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step(1);
            if (disp_sel === s) ok = 1'b1;
        end
    endtask

    task automatic wait_busy(input logic lvl, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step(1);
            if (busy_o === lvl) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_1m);
        rst_n = 1'b0;
        cap_tgl_i = 1'b0;
        freeze_i = 1'b0;
        @(negedge clk_1m);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        @(negedge clk_1m);
        rst_n = 1'b1;
        step(20);
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (disp_sel !== 4'hF || disp_seg !== 8'hFF) begin
            nerr++;
            $display("FAIL reset_dark: sel=%h seg=%h want F/FF", disp_sel, disp_seg);
        end
        nvec++;
        if (busy_o !== 1'b0 || drop_cnt_o !== 8'h00) begin
            nerr++;
            $display("FAIL reset_flags: busy=%b drop=%h want 0/00", busy_o, drop_cnt_o);
        end
        @(negedge clk_1m);
        rst_n = 1'b1;
        step(1);
        nvec++;
        if (disp_sel !== 4'hF) begin
            nerr++;
            $display("FAIL reset_blank1: sel=%h want F", disp_sel);
        end
        step(1);
        nvec++;
        if (disp_sel !== 4'hE || disp_seg !== 8'hC0) begin
            nerr++;
            $display("FAIL reset_digit0: sel=%h seg=%h want E/C0", disp_sel, disp_seg);
        end
    endtask

    task automatic test_single_capture();
        logic [7:0] exp_seg [4];
        bit ok;
        exp_seg[0] = 8'h46; exp_seg[1] = 8'h92;
        exp_seg[2] = 8'h88; exp_seg[3] = 8'hB0;
        toggle(16'h3A5C, 4'b0001);
        step(2);
        nvec++;
        if (busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL cap_latency_early: busy=%b want 0", busy_o);
        end
        step(1);
        nvec++;
        if (busy_o !== 1'b1) begin
            nerr++;
            $display("FAIL cap_latency_commit: busy=%b want 1", busy_o);
        end
        for (int k = 0; k < 4; k++) begin
            wait_sel(~(4'b0001 << k), 80, ok);
            nvec++;
            if (!ok || disp_seg !== exp_seg[k]) begin
                nerr++;
                $display("FAIL cap_digit%0d: ok=%b seg=%h want %h", k, ok, disp_seg, exp_seg[k]);
            end
        end
    endtask

    task automatic test_hold_pending();
        bit ok, seen;
        int n;
        wait_busy(1'b0, 100, ok);
        step(2);
        toggle(16'h1111, 4'b0000);
        step(3);
        nvec++;
        if (busy_o !== 1'b1) begin
            nerr++;
            $display("FAIL hold_commit: busy=%b want 1", busy_o);
        end
        toggle(16'h2222, 4'b0000);
        n = 0;
        seen = 1'b0;
        while (busy_o === 1'b1 && n < 80) begin
            step(1);
            n++;
            if (!seen && disp_sel !== 4'hF) begin
                seen = 1'b1;
                nvec++;
                if (disp_seg !== 8'hF9) begin
                    nerr++;
                    $display("FAIL hold_first_value: seg=%h want F9", disp_seg);
                end
            end
        end
        nvec++;
        if (n < 33 || n > 48) begin
            nerr++;
            $display("FAIL hold_duration: %0d cycles want 33..48", n);
        end
        step(1);
        nvec++;
        if (busy_o !== 1'b1 || drop_cnt_o !== 8'h00) begin
            nerr++;
            $display("FAIL hold_deferred: busy=%b drop=%h want 1/00", busy_o, drop_cnt_o);
        end
        wait_sel(4'hE, 80, ok);
        nvec++;
        if (!ok || disp_seg !== 8'hA4) begin
            nerr++;
            $display("FAIL hold_second_value: ok=%b seg=%h want A4", ok, disp_seg);
        end
    endtask

    task automatic test_overwrite_drop();
        bit ok;
        wait_busy(1'b0, 100, ok);
        step(2);
        toggle(16'h4444, 4'b0000);
        step(3);
        toggle(16'h5555, 4'b0000);
        step(3);
        toggle(16'h6666, 4'b0000);
        step(4);
        nvec++;
        if (drop_cnt_o !== 8'h01) begin
            nerr++;
            $display("FAIL drop_one: drop=%h want 01", drop_cnt_o);
        end
        wait_busy(1'b0, 100, ok);
        step(1);
        wait_sel(4'hB, 80, ok);
        nvec++;
        if (!ok || disp_seg !== 8'h82 || busy_o !== 1'b1) begin
            nerr++;
            $display("FAIL drop_last_value: ok=%b seg=%h busy=%b want 82/1", ok, disp_seg, busy_o);
        end
        for (int i = 0; i < 300; i++) begin
            toggle(16'(i), 4'b0000);
            step(3);
        end
        step(4);
        nvec++;
        if (drop_cnt_o !== 8'hFF) begin
            nerr++;
            $display("FAIL drop_saturate: drop=%h want FF", drop_cnt_o);
        end
    endtask

    task automatic test_freeze();
        logic [7:0] exp_seg [4];
        bit ok;
        exp_seg[0] = 8'h8E; exp_seg[1] = 8'h06;
        exp_seg[2] = 8'h86; exp_seg[3] = 8'h03;
        do_reset();
        step(2);
        toggle(16'h1234, 4'b0000);
        step(3);
        @(negedge clk_1m);
        freeze_i = 1'b1;
        toggle(16'hBEEF, 4'b1010);
        step(160);
        nvec++;
        if (busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL freeze_busy_falls: busy=%b want 0", busy_o);
        end
        wait_sel(4'hE, 80, ok);
        nvec++;
        if (!ok || disp_seg !== 8'h99) begin
            nerr++;
            $display("FAIL freeze_held_k0: ok=%b seg=%h want 99", ok, disp_seg);
        end
        wait_sel(4'h7, 80, ok);
        nvec++;
        if (!ok || disp_seg !== 8'hF9 || busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL freeze_held_k3: ok=%b seg=%h busy=%b want F9/0", ok, disp_seg, busy_o);
        end
        @(negedge clk_1m);
        freeze_i = 1'b0;
        step(1);
        nvec++;
        if (busy_o !== 1'b1) begin
            nerr++;
            $display("FAIL freeze_release_commit: busy=%b want 1", busy_o);
        end
        for (int k = 0; k < 4; k++) begin
            wait_sel(~(4'b0001 << k), 80, ok);
            nvec++;
            if (!ok || disp_seg !== exp_seg[k]) begin
                nerr++;
                $display("FAIL freeze_digit%0d: ok=%b seg=%h want %h", k, ok, disp_seg, exp_seg[k]);
            end
        end
    endtask

    task automatic test_event_at_expiry();
        int c0, t;
        bit ok;
        do_reset();
        step(2);
        toggle(16'h7777, 4'b0000);
        c0 = cyc + 3;
        t = (c0 / 16 + 1) * 16 + 32;
        step(3);
        toggle(16'h8888, 4'b0000);
        while (cyc < t - 2) step(1);
        toggle(16'h9999, 4'b0000);
        step(2);
        nvec++;
        if (busy_o !== 1'b0 || drop_cnt_o !== 8'h00) begin
            nerr++;
            $display("FAIL expiry_timer_zero: busy=%b drop=%h want 0/00", busy_o, drop_cnt_o);
        end
        step(1);
        nvec++;
        if (busy_o !== 1'b1 || drop_cnt_o !== 8'h01) begin
            nerr++;
            $display("FAIL expiry_commit: busy=%b drop=%h want 1/01", busy_o, drop_cnt_o);
        end
        wait_sel(4'hD, 80, ok);
        nvec++;
        if (!ok || disp_seg !== 8'h90) begin
            nerr++;
            $display("FAIL expiry_value: ok=%b seg=%h want 90", ok, disp_seg);
        end
        wait_busy(1'b0, 100, ok);
        step(5);
        nvec++;
        if (!ok || busy_o !== 1'b0 || drop_cnt_o !== 8'h01) begin
            nerr++;
            $display("FAIL expiry_no_stale: ok=%b busy=%b drop=%h want 0/01", ok, busy_o, drop_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_hold_pending();
        test_overwrite_drop();
        test_freeze();
        test_event_at_expiry();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
